// File: rtl/truth_table_8_5_checker.sv
// Purpose: registered 8->5 function (y = x[3:0] + x[7:4]) evaluated twice, as
//          sum-of-minterms and product-of-maxterms, with a mismatch flag.
// Latency: 1 cycle. No backpressure; accepts a new sample every cycle.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst_n      synchronous active-low reset
//   i_valid    i_x is valid this cycle
//   i_x[7:0]   function argument, bit 0 = x0 ... bit 7 = x7
//   o_y_ddnf   registered result of the sum-of-minterms realization
//   o_y_dknf   registered result of the product-of-maxterms realization
//   o_valid    outputs belong to a sample taken on the previous edge
//   o_error    the two realizations disagreed for that sample
//
// Optional build macro TT_ERR_STICKY_EN adds:
//   o_err_sticky    set by any mismatching valid sample, cleared by reset
//   o_err_count     saturating count of mismatching valid samples

module truth_table_8_5_checker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_x,
    output logic [4:0] o_y_ddnf,
    output logic [4:0] o_y_dknf,
    output logic       o_valid,
`ifdef TT_ERR_STICKY_EN
    output logic       o_err_sticky,
    output logic [7:0] o_err_count,
`endif
    output logic       o_error
);

    // ------------------------------------------------------------------
    // Truth table of F. Evaluated on constant codes only, so it folds to
    // constants at elaboration; no adder ever sees i_x.
    // ------------------------------------------------------------------
    function automatic logic [4:0] f_table(input logic [7:0] code);
        logic [4:0] lo;
        logic [4:0] hi;
        lo = {1'b0, code[3:0]};
        hi = {1'b0, code[7:4]};
        return lo + hi;
    endfunction

    logic [4:0] ddnf_comb;
    logic [4:0] dknf_comb;
    logic       mismatch;

    // ------------------------------------------------------------------
    // Disjunctive path: OR of minterms. A minterm for code k is the AND of
    // x_i where bit i of k is 1 and ~x_i where it is 0.
    // ------------------------------------------------------------------
    always_comb begin
        logic       minterm;
        logic [7:0] code;
        logic [4:0] row;
        ddnf_comb = '0;
        minterm   = 1'b0;
        code      = '0;
        row       = '0;
        for (int k = 0; k < 256; k++) begin
            code    = 8'(k);
            row     = f_table(code);
            minterm = 1'b1;
            for (int i = 0; i < 8; i++) begin
                minterm = minterm & (code[i] ? i_x[i] : ~i_x[i]);
            end
            for (int j = 0; j < 5; j++) begin
                if (row[j]) begin
                    ddnf_comb[j] = ddnf_comb[j] | minterm;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Conjunctive path: AND of maxterms. A maxterm for code k is the OR of
    // ~x_i where bit i of k is 1 and x_i where it is 0; it is 0 only when
    // i_x == k. Built from its own literals, sharing nothing with the
    // disjunctive path.
    // ------------------------------------------------------------------
    always_comb begin
        logic       maxterm;
        logic [7:0] code;
        logic [4:0] row;
        dknf_comb = '1;
        maxterm   = 1'b0;
        code      = '0;
        row       = '0;
        for (int k = 0; k < 256; k++) begin
            code    = 8'(k);
            row     = f_table(code);
            maxterm = 1'b0;
            for (int i = 0; i < 8; i++) begin
                maxterm = maxterm | (code[i] ? ~i_x[i] : i_x[i]);
            end
            for (int j = 0; j < 5; j++) begin
                if (!row[j]) begin
                    dknf_comb[j] = dknf_comb[j] & maxterm;
                end
            end
        end
    end

    assign mismatch = (ddnf_comb != dknf_comb);

    // ------------------------------------------------------------------
    // Output register. Results hold while i_valid is low; valid/error are
    // single-cycle qualifiers of the sample taken on this edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_y_ddnf <= '0;
            o_y_dknf <= '0;
            o_valid  <= 1'b0;
            o_error  <= 1'b0;
        end else if (i_valid) begin
            o_y_ddnf <= ddnf_comb;
            o_y_dknf <= dknf_comb;
            o_valid  <= 1'b1;
            o_error  <= mismatch;
        end else begin
            o_valid  <= 1'b0;
            o_error  <= 1'b0;
        end
    end

`ifdef TT_ERR_STICKY_EN
    // Sticky flag and counter update on the same edge that raises o_error,
    // so they are visible in the same cycle as the offending result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_err_sticky <= 1'b0;
            o_err_count  <= '0;
        end else if (i_valid && mismatch) begin
            o_err_sticky <= 1'b1;
            if (o_err_count != 8'hFF) begin
                o_err_count <= o_err_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_8_5_checker.sv
module tb_truth_table_8_5_checker;

    logic       clk;
    logic       rst_n;
    logic       i_valid;
    logic [7:0] i_x;
    logic [4:0] o_y_ddnf;
    logic [4:0] o_y_dknf;
    logic       o_valid;
    logic       o_error;
`ifdef TT_ERR_STICKY_EN
    logic       o_err_sticky;
    logic [7:0] o_err_count;
`endif

    int checks   = 0;
    int failures = 0;

    truth_table_8_5_checker dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .i_x      (i_x),
        .o_y_ddnf (o_y_ddnf),
        .o_y_dknf (o_y_dknf),
        .o_valid  (o_valid),
`ifdef TT_ERR_STICKY_EN
        .o_err_sticky (o_err_sticky),
        .o_err_count  (o_err_count),
`endif
        .o_error  (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [7:0] x;
        logic [4:0] exp_y;
        logic       exp_valid;
        string      name;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic v, input logic [7:0] x);
        rst_n   = r;
        i_valid = v;
        i_x     = x;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string name, input logic [4:0] y, input logic vld);
        chk({name, ".ddnf"},  int'(o_y_ddnf), int'(y));
        chk({name, ".dknf"},  int'(o_y_dknf), int'(y));
        chk({name, ".valid"}, int'(o_valid),  int'(vld));
        chk({name, ".error"}, int'(o_error),  0);
    endtask

    initial begin
        logic [4:0] exp;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_x     = '0;
        @(negedge clk);

        // {rst_n, valid, x, expected y, expected valid, name}
        vecs.push_back('{1'b0, 1'b1, 8'hFF, 5'd0,  1'b0, "rst0"});
        vecs.push_back('{1'b0, 1'b1, 8'hFF, 5'd0,  1'b0, "rst1"});
        vecs.push_back('{1'b1, 1'b0, 8'hFF, 5'd0,  1'b0, "idle_after_rst"});
        vecs.push_back('{1'b1, 1'b1, 8'h00, 5'd0,  1'b1, "x00"});
        vecs.push_back('{1'b1, 1'b1, 8'hFF, 5'd30, 1'b1, "xFF"});
        vecs.push_back('{1'b1, 1'b1, 8'h5A, 5'd15, 1'b1, "x5A"});
        vecs.push_back('{1'b1, 1'b1, 8'h80, 5'd8,  1'b1, "x80"});
        vecs.push_back('{1'b1, 1'b1, 8'h0F, 5'd15, 1'b1, "x0F"});
        vecs.push_back('{1'b1, 1'b1, 8'hF0, 5'd15, 1'b1, "xF0"});
        vecs.push_back('{1'b1, 1'b1, 8'h33, 5'd6,  1'b1, "x33"});
        vecs.push_back('{1'b1, 1'b0, 8'hFF, 5'd6,  1'b0, "hold1"});
        vecs.push_back('{1'b1, 1'b0, 8'h12, 5'd6,  1'b0, "hold2"});
        vecs.push_back('{1'b1, 1'b1, 8'h9E, 5'd23, 1'b1, "x9E"});
        vecs.push_back('{1'b0, 1'b0, 8'h77, 5'd0,  1'b0, "rst_idle"});
        vecs.push_back('{1'b1, 1'b1, 8'h01, 5'd1,  1'b1, "x01"});

        foreach (vecs[n]) begin
            step(vecs[n].rst_n, vecs[n].valid, vecs[n].x);
            chk_outs(vecs[n].name, vecs[n].exp_y, vecs[n].exp_valid);
        end

        // Exhaustive back-to-back sweep with a reset pulse at code 128;
        // the interrupted sample is dropped and the sweep resumes there.
        for (int v = 0; v < 256; v++) begin
            if (v == 128) begin
                step(1'b0, 1'b1, 8'(v));
                chk_outs("sweep_rst", 5'd0, 1'b0);
            end
            exp = 5'(v % 16) + 5'(v / 16);
            step(1'b1, 1'b1, 8'(v));
            chk_outs($sformatf("sweep_%0d", v), exp, 1'b1);
        end

        // Valid drop right after 0x33 at full rate.
        step(1'b1, 1'b1, 8'h33);
        chk_outs("drop_x33", 5'd6, 1'b1);
        step(1'b1, 1'b0, 8'hAA);
        chk_outs("drop_hold", 5'd6, 1'b0);

`ifdef TT_ERR_STICKY_EN
        step(1'b0, 1'b0, 8'h00);
        chk("st_rst.sticky", int'(o_err_sticky), 0);
        chk("st_rst.count",  int'(o_err_count),  0);
        force dut.dknf_comb = 5'b00001;
        step(1'b1, 1'b1, 8'h00);
        chk("st_f1.error",  int'(o_error),      1);
        chk("st_f1.sticky", int'(o_err_sticky), 1);
        chk("st_f1.count",  int'(o_err_count),  1);
        chk("st_f1.dknf",   int'(o_y_dknf),     1);
        step(1'b1, 1'b0, 8'h00);
        chk("st_idle.error",  int'(o_error),     0);
        chk("st_idle.count",  int'(o_err_count), 1);
        step(1'b1, 1'b1, 8'h00);
        chk("st_f2.count",  int'(o_err_count),  2);
        release dut.dknf_comb;
        step(1'b1, 1'b1, 8'h11);
        chk("st_ok.error",  int'(o_error),      0);
        chk("st_ok.sticky", int'(o_err_sticky), 1);
        chk("st_ok.count",  int'(o_err_count),  2);
        step(1'b0, 1'b0, 8'h00);
        chk("st_clr.sticky", int'(o_err_sticky), 0);
        chk("st_clr.count",  int'(o_err_count),  0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
